// File: rtl/nf_fetch_unit.sv
`default_nettype none
// nf_fetch_unit: rate-throttled instruction fetcher feeding a DEPTH-entry buffer.
// A redirect flushes the buffer and drops the data of any request still in flight.
module nf_fetch_unit #(
  parameter int unsigned   AW       = 32,
  parameter logic [AW-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned   DEPTH    = 2,
  parameter int unsigned   DIV_W    = 26
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [DIV_W-1:0] div,
  output logic             mem_req,
  output logic [AW-1:0]    mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [AW-1:0]    instr_pc,
  input  logic             instr_ready,
  input  logic             redirect,
  input  logic [AW-1:0]    redirect_pc
);

  localparam int unsigned   PW   = $clog2(DEPTH);
  localparam int unsigned   CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q;
  logic             strobe;
  logic             run_q;
  logic [AW-1:0]    fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [31:0]      buf_data_q [DEPTH];
  logic [AW-1:0]    buf_pc_q   [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push;
  logic             pop;
  logic [AW-1:0]    redirect_base;
  logic             unused_redirect_lsb;

  assign strobe              = (div_cnt_q == div);
  assign redirect_base       = {redirect_pc[AW-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr       = buf_data_q[rd_ptr_q];
  assign instr_pc    = buf_pc_q[rd_ptr_q];
  assign mem_req     = (state_q != IDLE);
  assign mem_addr    = mem_addr_q;

  // run_q holds off the first request until one full cycle after reset release.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run_q && strobe && (count_q < FULL) && !redirect) begin
          state_d    = WAIT;
          mem_addr_d = fetch_pc_q;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d = IDLE;
          push    = !redirect;
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (push) begin
      fetch_pc_d = fetch_pc_q + AW'(4);
    end
    if (redirect) begin
      fetch_pc_d = redirect_base;
    end
  end

  always_comb begin
    count_d = count_q;
    if (redirect) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt_q  <= '0;
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      div_cnt_q  <= strobe ? '0 : div_cnt_q + DIV_W'(1);
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      count_q    <= count_d;
      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
      end
      if (push) begin
        buf_data_q[wr_ptr_q] <= mem_rdata;
        buf_pc_q[wr_ptr_q]   <= mem_addr_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nf_fetch_unit.sv
`default_nettype none
// Bench for nf_fetch_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a second instance for PC wrap.
module tb_nf_fetch_unit;
  localparam int AW    = 32;
  localparam int DEPTH = 2;
  localparam int DIV_W = 26;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic             mem_req;
  logic [AW-1:0]    mem_addr;
  logic             mem_ack = 1'b0;
  logic [31:0]      mem_rdata;
  logic             instr_valid;
  logic [31:0]      instr;
  logic [AW-1:0]    instr_pc;
  logic             instr_ready = 1'b0;
  logic             redirect = 1'b0;
  logic [AW-1:0]    redirect_pc = '0;

  logic             w_req;
  logic [AW-1:0]    w_addr;
  logic [31:0]      w_rdata;
  logic             w_valid;
  logic [31:0]      w_instr;
  logic [AW-1:0]    w_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign mem_rdata = word_at(mem_addr);
  assign w_rdata   = word_at(w_addr);

  nf_fetch_unit #(.AW(AW), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .resetn(resetn), .div(div),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  nf_fetch_unit #(.AW(AW), .RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut_wrap (
    .clk(clk), .resetn(resetn), .div('0),
    .mem_req(w_req), .mem_addr(w_addr), .mem_ack(1'b1), .mem_rdata(w_rdata),
    .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_pc), .instr_ready(1'b1),
    .redirect(1'b0), .redirect_pc('0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: request slot, fetch pointer and a queue of {pc, word}.
  int unsigned  m_cnt;
  bit           m_run, m_pend, m_drop;
  logic [31:0]  m_addr, m_pc;
  logic [63:0]  m_q[$];

  task automatic model_reset();
    m_cnt  = 0;
    m_run  = 0;
    m_pend = 0;
    m_drop = 0;
    m_addr = 32'h0;
    m_pc   = 32'h0;
    m_q.delete();
  endtask

  task automatic model_step(input logic [DIV_W-1:0] d, input logic ack, input logic rdy,
                            input logic rdr, input logic [31:0] rpc);
    bit strobe;
    bit pop;
    bit push;
    strobe = (m_cnt == d);
    pop    = (m_q.size() != 0) && rdy;
    push   = 0;
    if (!m_pend) begin
      if (m_run && strobe && (m_q.size() < DEPTH) && !rdr) begin
        m_pend = 1;
        m_drop = 0;
        m_addr = m_pc;
      end
    end else if (ack) begin
      m_pend = 0;
      push   = !m_drop && !rdr;
    end else if (rdr) begin
      m_drop = 1;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      m_q.push_back({m_addr, word_at(m_addr)});
      m_pc = m_addr + 32'd4;
    end
    if (rdr) begin
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end
    m_cnt = strobe ? 0 : m_cnt + 1;
    m_run = 1;
  endtask

  always @(posedge clk or negedge resetn) begin : compare
    if (!resetn) model_reset();
    else model_step(div, mem_ack, instr_ready, redirect, redirect_pc);
    #1;
    check("mem_req", mem_req, m_pend);
    check("mem_addr", mem_addr, m_addr);
    check("instr_valid", instr_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("instr", instr, m_q[0][31:0]);
      check("instr_pc", instr_pc, m_q[0][63:32]);
    end
    if (!resetn) begin
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
    end
  end

  initial begin : wrap_check
    int got;
    logic [31:0] a [2];
    got  = 0;
    a[0] = '0;
    a[1] = '0;
    @(posedge resetn);
    for (int c = 0; c < 20 && got < 2; c++) begin
      @(negedge clk);
      if (w_req) begin
        a[got] = w_addr;
        got++;
      end
    end
    check("wrap_req_count", got, 2);
    check("wrap_first_addr", a[0], 32'hFFFF_FFFC);
    check("wrap_second_addr", a[1], 32'h0000_0000);
  end

  initial begin : stim
    int          hs;
    int          delivered;
    logic [31:0] exp_pc;
    logic [31:0] bp_addr;
    bit          found;
    bit          prev_req;
    int          last_rise;
    int          rises;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_instr_valid", instr_valid, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("no_early_req", mem_req, 0);
    @(negedge clk);
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, 32'h0);

    // Streaming
    mem_ack = 1'b1;
    instr_ready = 1'b1;
    exp_pc = 32'h0;
    delivered = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (instr_valid) begin
        check("stream_pc", instr_pc, exp_pc);
        check("stream_word", instr, word_at(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
    end
    check("stream_count_ok", delivered >= 15, 1);

    // Backpressure
    redirect = 1'b1;
    redirect_pc = 32'h200;
    instr_ready = 1'b0;
    @(negedge clk);
    redirect = 1'b0;
    hs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req && mem_ack) hs++;
    end
    check("bp_pushes", hs, 2);
    check("bp_req_idle", mem_req, 0);
    check("bp_head_pc", instr_pc, 32'h200);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    hs = 0;
    bp_addr = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_req && mem_ack) begin
        hs++;
        bp_addr = mem_addr;
      end
    end
    check("bp_refill_count", hs, 1);
    check("bp_refill_addr", bp_addr, 32'h208);

    // Redirect while a request is outstanding
    mem_ack = 1'b0;
    instr_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (mem_req) found = 1;
    end
    check("rd_wait_seen", found, 1);
    check("rd_old_addr", mem_addr, 32'h20C);
    redirect = 1'b1;
    redirect_pc = 32'h103;
    @(negedge clk);
    redirect = 1'b0;
    check("rd_hold_req", mem_req, 1);
    check("rd_hold_addr", mem_addr, 32'h20C);
    check("rd_flushed", instr_valid, 0);
    @(negedge clk);
    check("rd_hold_addr2", mem_addr, 32'h20C);
    mem_ack = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (instr_valid) begin
        check("rd_first_pc", instr_pc, 32'h100);
        found = 1;
      end
    end
    check("rd_delivered", found, 1);

    // Random traffic, div = 0
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      mem_ack     = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
    end

    // Throttle
    div = 26'd3;
    mem_ack = 1'b1;
    instr_ready = 1'b1;
    redirect = 1'b0;
    prev_req = 1;
    last_rise = -1;
    rises = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        if (last_rise >= 0) check("throttle_gap", c - last_rise, 4);
        last_rise = c;
        rises++;
      end
      prev_req = mem_req;
    end
    check("throttle_rises_ok", rises >= 8, 1);

    // Reset in the middle of a request
    mem_ack = 1'b0;
    found = 0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(negedge clk);
      if (mem_req) found = 1;
    end
    check("mid_wait_seen", found, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_addr", mem_addr, 32'h0);
    div = 26'd2;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    found = 0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(negedge clk);
      if (mem_req) begin
        check("post_rst_addr", mem_addr, 32'h0);
        found = 1;
      end
    end
    check("post_rst_req_seen", found, 1);

    // Random traffic, div = 2
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      mem_ack     = ($urandom_range(0, 2) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
    end
    redirect = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nf_fetch_unit.md
NF_FETCH_UNIT -- requirements
Module: nf_fetch_unit

Interface
REQ-001 Parameters SHALL be:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- AW, 32, address width.
- DEPTH, 2, instruction buffer entries; power of two, at least 2.
- DIV_W, 26, width of the issue-rate divider threshold.

REQ-002 Ports SHALL be:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  reset; asynchronous, active-low.
- div  input  DIV_W  issue-rate threshold; 0 allows an issue every cycle.
- mem_req  output  1  instruction memory request.
- mem_addr  output  AW  request byte address; bits [1:0] always 0.
- mem_ack  input  1  memory accepts request and returns mem_rdata this cycle.
- mem_rdata  input  32  fetched instruction word.
- instr_valid  output  1  buffer head holds a valid instruction.
- instr  output  32  instruction at buffer head.
- instr_pc  output  AW  address of instr.
- instr_ready  input  1  consumer takes head when instr_valid is high.
- redirect  input  1  branch/jump redirect request.
- redirect_pc  input  AW  redirect target; bits [1:0] are ignored and treated as 0.

Function
REQ-003 The divider counter SHALL increment each cycle.
- Strobe asserts when the counter equals div; the counter clears on that cycle.
- With div=0 the strobe is high every cycle.

REQ-004 The FSM SHALL have three states: IDLE, WAIT and DROP.

REQ-005 IDLE -> WAIT SHALL occur when the strobe is high, buffer count < DEPTH and redirect=0.
- mem_req rises the next cycle with mem_addr = fetch_pc.

REQ-006 In WAIT, mem_req SHALL stay high and mem_addr SHALL stay stable until mem_ack.
- At most one request is outstanding.

REQ-007 On WAIT with mem_ack and no redirect:
- {fetch_pc, mem_rdata} is pushed to the buffer.
- fetch_pc increments by 4, modulo 2^AW.
- The FSM returns to IDLE and mem_req deasserts the following cycle.

REQ-008 Buffer pop SHALL occur on instr_valid && instr_ready.
- instr_valid = (count != 0).
- instr and instr_pc come from the head register with zero combinational path from mem_rdata.

REQ-009 A simultaneous push and pop SHALL leave count unchanged.
- Pop on an empty buffer has no effect.
- No push is issued when no slot is free: the REQ-005 check is sufficient because pops only reduce count.

REQ-010 On redirect=1 in any state:
- The buffer is flushed; instr_valid is 0 the next cycle.
- fetch_pc becomes {redirect_pc[AW-1:2], 2'b00}.
- Any push that cycle is suppressed.

REQ-011 Redirect in WAIT without mem_ack SHALL move the FSM to DROP.
- Redirect in WAIT with mem_ack SHALL discard the data and move the FSM to IDLE.

REQ-012 In DROP, mem_req SHALL stay high at the old address until mem_ack.
- The returned data is discarded; the FSM then moves to IDLE.
- A further redirect in DROP updates fetch_pc only.

REQ-013 A pop in the same cycle as redirect SHALL still be accepted by the consumer.
- The flush takes precedence for buffer state.

REQ-014 Buffer read/write pointers SHALL wrap modulo DEPTH.
- count spans 0..DEPTH.

Reset
REQ-015 Asserting resetn low SHALL, asynchronously and at any time including mid-request:
- set mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0;
- set count=0, pointers=0, divider counter=0, fetch_pc=RESET_PC, FSM=IDLE.

REQ-016 The first request after release SHALL be at RESET_PC, no earlier than one cycle after resetn rises.

Verification
REQ-017 Streaming: div=0, mem_ack tied 1, instr_ready=1.
- Expect instr_pc sequence 0,4,8,...
- Every instruction is delivered in order with no drops or duplicates.

REQ-018 Backpressure: DEPTH=2, instr_ready=0.
- Exactly 2 pushes occur, then mem_req stays 0.
- instr_ready=1 for one cycle -> one pop, then one new request.

REQ-019 Redirect while WAIT, mem_ack delayed 3 cycles, redirect_pc=32'h103.
- mem_req is held at the old address until ack; that data is discarded.
- The next request is at 32'h100; instr_valid stays 0 until the 32'h100 word is pushed.

REQ-020 Throttle: div=3, mem_ack tied 1.
- Requests are spaced 4 cycles apart.

REQ-021 Mid-request reset: resetn pulsed low while in WAIT.
- mem_req and instr_valid drop immediately.
- After release, the first mem_addr = RESET_PC.

REQ-022 Wrap: RESET_PC=32'hFFFF_FFFC.
- Second fetch address is 32'h0000_0000.
